axis_1553_encoder_arbiter: RTL
==============================

AXIS_1553_ENCODER_ARBITER -- requirements
Module: axis_1553_encoder_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of requesting AXIS 1553 word sources (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the 1553 data word width.
REQ-003 SHALL have parameter USER_WIDTH, default 8, the 1553 word type/status sideband width.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port s_axis_tdata, input, NUM_SRC*DATA_WIDTH, packed source words; source i occupies slice i.
REQ-007 SHALL have port s_axis_tuser, input, NUM_SRC*USER_WIDTH, packed source sideband.
REQ-008 SHALL have port s_axis_tlast, input, NUM_SRC, per-source end-of-message marker.
REQ-009 SHALL have port s_axis_tvalid, input, NUM_SRC, per-source valid.
REQ-010 SHALL have port s_axis_tready, output, NUM_SRC, per-source ready.
REQ-011 SHALL have port m_axis_tdata, output, DATA_WIDTH, word to the string encoder.
REQ-012 SHALL have port m_axis_tuser, output, USER_WIDTH, sideband to the string encoder.
REQ-013 SHALL have port m_axis_tdest, output, clog2(NUM_SRC) (min 1), index of the originating source.
REQ-014 SHALL have port m_axis_tlast, output, 1, forwarded tlast.
REQ-015 SHALL have port m_axis_tvalid, output, 1, output valid.
REQ-016 SHALL have port m_axis_tready, input, 1, encoder ready.

Function
REQ-017 SHALL hold a single registered output slot; the slot is free when m_axis_tvalid=0 or m_axis_tready=1.
REQ-018 SHALL grant at most one source per cycle; s_axis_tready[g]=1 only for grant g, only while the slot is free and tvalid[g]=1; all other tready bits are 0.
REQ-019 SHALL select the grant round-robin: search from (last_grant+1) mod NUM_SRC upward with wrap, first source with tvalid=1 wins.
REQ-020 SHALL update last_grant only on a completed source handshake (tvalid & tready).
REQ-021 SHALL load tdata/tuser/tlast and tdest=g into the slot on a source handshake, asserting m_axis_tvalid the next cycle (latency 1).
REQ-022 SHALL clear m_axis_tvalid when m_axis_tready=1 and no source handshake occurs in the same cycle.
REQ-023 SHALL, on simultaneous output drain and source handshake, replace the slot contents with no bubble, sustaining one word per cycle.
REQ-024 SHALL hold m_axis_* stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 SHALL produce no grant and no tready when all tvalid are 0; last_grant is unchanged.
REQ-026 SHALL never drop or duplicate a word; source order within one source is preserved.

Reset
REQ-027 SHALL, while rst=1, drive m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tdest=0, m_axis_tlast=0, s_axis_tready=0, last_grant=NUM_SRC-1 (so source 0 is searched first), lock state IDLE.
REQ-028 SHALL, on reset mid-transfer, discard the slot contents; the first word after reset is arbitrated afresh.

Configuration
REQ-029 SHALL support macro ARB_MSG_LOCK_EN; when defined, the FSM has states IDLE and LOCKED: a handshake with tlast=0 moves IDLE->LOCKED and holds the grant on that source regardless of other tvalid until its handshake with tlast=1, then LOCKED->IDLE.
REQ-030 SHALL, without ARB_MSG_LOCK_EN, ignore tlast for arbitration (forwarded only) and re-arbitrate after every word.

Structure
REQ-031 SHALL place the round-robin search as sub-module rr_grant_select (inputs: request vector, last_grant; output: grant index, grant valid), combinational.
REQ-032 SHALL place lock FSM state encoding and the clog2 width helper in package axis_1553_pkg, shared with the encoder core.

Verification
REQ-033 SHALL verify: tvalid=2'b11 continuously, m_axis_tready=1 -> tdest alternates 0,1,0,1, one word per cycle.
REQ-034 SHALL verify: only source 1 valid with tdata 0x0000..0x0009 -> ten words out in order, tdest=1, tready[0]=0 throughout.
REQ-035 SHALL verify: m_axis_tready randomized 50% with tuser rotating from 8'b00000111 -> output matches a scoreboard exactly, stable while stalled.
REQ-036 SHALL verify with ARB_MSG_LOCK_EN: source 0 sends 3 words (tlast on 3rd), source 1 valid throughout -> three tdest=0 words then tdest=1.
REQ-037 SHALL verify: rst=1 for one cycle while m_axis_tvalid=1 -> next cycle m_axis_tvalid=0, and the next grant goes to source 0.

Source files
------------

// File: rtl/axis_1553_pkg.sv
// Shared types for the 1553 encoder path: lock FSM states, width helper.
// No ports; imported by the arbiter, its grant selector and the encoder core.
package axis_1553_pkg;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // clog2 with a floor of 1 so single-bit index ports stay legal
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin search starting one past last_i, with wrap.
// Ports: req_i request vector, last_i last grant; gnt_o index, gnt_valid_o.
module rr_grant_select
    import axis_1553_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   gnt_o,
    output logic               gnt_valid_o
);

    // Walk offsets from farthest to nearest so the nearest requester
    // after last_i is the final (winning) assignment.
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            int idx;
            idx = (int'(last_i) + off) % NUM_SRC;
            if (req_i[idx]) begin
                gnt_o       = IDX_W'(idx);
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_1553_encoder_arbiter.sv
// Round-robin AXIS arbiter feeding one registered slot to the 1553 encoder.
// Ports: s_axis_* per-source words in, m_axis_* slot out with tdest = source;
// aclk, rst (sync, active-high). Define ARB_MSG_LOCK_EN for message locking.
module axis_1553_encoder_arbiter
    import axis_1553_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 8,
    localparam int DEST_W    = clog2_min1(NUM_SRC)
) (
    input  logic                           aclk,
    input  logic                           rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_SRC*USER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [DEST_W-1:0]              m_axis_tdest,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready
);

    logic [DEST_W-1:0]     last_q, last_d;
    logic [DEST_W-1:0]     rr_gnt, gnt;
    logic                  rr_valid, gnt_valid;
    logic                  slot_free, src_hs, sel_last;

    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [USER_WIDTH-1:0] m_user_q;
    logic [DEST_W-1:0]     m_dest_q;
    logic                  m_last_q;

    rr_grant_select #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (DEST_W)
    ) u_rr (
        .req_i       (s_axis_tvalid),
        .last_i      (last_q),
        .gnt_o       (rr_gnt),
        .gnt_valid_o (rr_valid)
    );

    assign sel_last = s_axis_tlast[gnt];

`ifdef ARB_MSG_LOCK_EN
    lock_state_e       state_q, state_d;
    logic [DEST_W-1:0] lock_src_q, lock_src_d;

    // While locked the owner keeps the grant even if it pauses tvalid.
    always_comb begin
        gnt       = rr_gnt;
        gnt_valid = rr_valid;
        if (state_q == LOCK_LOCKED) begin
            gnt       = lock_src_q;
            gnt_valid = s_axis_tvalid[lock_src_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        if (src_hs) begin
            unique case (state_q)
                LOCK_IDLE: begin
                    if (!sel_last) begin
                        state_d    = LOCK_LOCKED;
                        lock_src_d = gnt;
                    end
                end
                LOCK_LOCKED: begin
                    if (sel_last) state_d = LOCK_IDLE;
                end
                default: state_d = LOCK_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q    <= LOCK_IDLE;
            lock_src_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
        end
    end
`else
    // tlast is only forwarded; every word is arbitrated on its own.
    assign gnt       = rr_gnt;
    assign gnt_valid = rr_valid;
`endif

    assign slot_free = !m_valid_q || m_axis_tready;
    assign src_hs    = gnt_valid && slot_free && !rst;
    assign last_d    = src_hs ? gnt : last_q;

    always_comb begin
        s_axis_tready = '0;
        if (src_hs) s_axis_tready[gnt] = 1'b1;
    end

    // A drain and a load in the same cycle simply overwrite the slot.
    always_ff @(posedge aclk) begin
        if (rst) begin
            last_q    <= DEST_W'(NUM_SRC - 1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_dest_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            if (src_hs) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_axis_tdata[gnt*DATA_WIDTH +: DATA_WIDTH];
                m_user_q  <= s_axis_tuser[gnt*USER_WIDTH +: USER_WIDTH];
                m_dest_q  <= gnt;
                m_last_q  <= sel_last;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tdest  = m_dest_q;
    assign m_axis_tlast  = m_last_q;

endmodule
